// File: rtl/iobus_arbiter_if.sv
// Signal bundle joining two requesters and one MCS-style IO bus target through the arbiter.
// The master view belongs to the arbiter, which masters the shared target bus.
interface iobus_arbiter_if;
  logic        m0_req,   m1_req;
  logic        m0_we,    m1_we;
  logic [31:0] m0_addr,  m1_addr;
  logic [3:0]  m0_be,    m1_be;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ack,   m1_ack;
  logic        m0_err,   m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_addr_strobe, s_read_strobe, s_write_strobe;
  logic [31:0] s_address;
  logic [3:0]  s_byte_enable;
  logic [31:0] s_write_data;
  logic [31:0] s_read_data;
  logic        s_ready;
  logic        busy;

  modport master (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_be, m1_be,
    input  m0_wdata, m1_wdata, s_read_data, s_ready,
    output m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
    output s_addr_strobe, s_read_strobe, s_write_strobe, s_address, s_byte_enable,
    output s_write_data, busy
  );

  modport slave (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_be, m1_be,
    output m0_wdata, m1_wdata, s_read_data, s_ready,
    input  m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
    input  s_addr_strobe, s_read_strobe, s_write_strobe, s_address, s_byte_enable,
    input  s_write_data, busy
  );
endinterface

// File: rtl/iobus_arbiter.sv
// Round-robin arbiter giving two requesters one-at-a-time access to an IO bus target,
// with a bounded wait that completes with an error instead of hanging.
module iobus_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic           clk,
  input  logic           rst_n,
  iobus_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StStrobe, StWait, StDone} state_e;

  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  state_e      r_state, w_state_d;
  logic        r_last_grant, w_last_grant_d;
  logic [15:0] r_cnt, w_cnt_d;
  logic        r_we, w_we_d;
  logic [31:0] r_address, w_address_d;
  logic [3:0]  r_be, w_be_d;
  logic [31:0] r_wdata, w_wdata_d;
  logic        r_addr_stb, w_addr_stb_d;
  logic        r_rd_stb, w_rd_stb_d;
  logic        r_wr_stb, w_wr_stb_d;
  logic [1:0]  r_ack, w_ack_d;
  logic [1:0]  r_err, w_err_d;
  logic [31:0] r_rdata0, w_rdata0_d;
  logic [31:0] r_rdata1, w_rdata1_d;
  logic        r_busy, w_busy_d;
  logic        w_grant1, w_fin, w_timeout;
  logic [31:0] w_rd_val;

  // m1 wins when alone, or when both ask and m0 was served last.
  assign w_grant1 = bus.m1_req & (~bus.m0_req | ~r_last_grant);

  always_comb begin
    w_state_d      = r_state;
    w_last_grant_d = r_last_grant;
    w_cnt_d        = r_cnt;
    w_we_d         = r_we;
    w_address_d    = r_address;
    w_be_d         = r_be;
    w_wdata_d      = r_wdata;
    w_addr_stb_d   = 1'b0;
    w_rd_stb_d     = 1'b0;
    w_wr_stb_d     = 1'b0;
    w_ack_d        = 2'b00;
    w_err_d        = 2'b00;
    w_rdata0_d     = r_rdata0;
    w_rdata1_d     = r_rdata1;
    w_fin          = 1'b0;
    w_timeout      = 1'b0;
    w_rd_val       = bus.s_read_data;

    unique case (r_state)
      StIdle: begin
        if (bus.m0_req || bus.m1_req) begin
          w_state_d      = StStrobe;
          w_last_grant_d = w_grant1;
          w_we_d         = w_grant1 ? bus.m1_we    : bus.m0_we;
          w_address_d    = w_grant1 ? bus.m1_addr  : bus.m0_addr;
          w_be_d         = w_grant1 ? bus.m1_be    : bus.m0_be;
          w_wdata_d      = w_grant1 ? bus.m1_wdata : bus.m0_wdata;
          w_addr_stb_d   = 1'b1;
          w_rd_stb_d     = ~w_we_d;
          w_wr_stb_d     = w_we_d;
        end
      end
      StStrobe: begin
        w_cnt_d   = '0;
        w_state_d = StWait;
      end
      StWait: begin
        // A ready arriving on the final allowed cycle still completes normally.
        if (bus.s_ready) begin
          w_state_d = StDone;
          w_fin     = 1'b1;
        end else if (r_cnt == CntLast) begin
          w_state_d = StDone;
          w_fin     = 1'b1;
          w_timeout = 1'b1;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    if (w_fin) begin
      w_ack_d[r_last_grant] = 1'b1;
      w_err_d[r_last_grant] = w_timeout;
      if (!r_we) begin
        w_rd_val = w_timeout ? ERR_DATA : bus.s_read_data;
        if (r_last_grant) w_rdata1_d = w_rd_val;
        else              w_rdata0_d = w_rd_val;
      end
    end

    w_busy_d = (w_state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_address    <= '0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_addr_stb   <= 1'b0;
      r_rd_stb     <= 1'b0;
      r_wr_stb     <= 1'b0;
      r_ack        <= 2'b00;
      r_err        <= 2'b00;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_last_grant <= w_last_grant_d;
      r_cnt        <= w_cnt_d;
      r_we         <= w_we_d;
      r_address    <= w_address_d;
      r_be         <= w_be_d;
      r_wdata      <= w_wdata_d;
      r_addr_stb   <= w_addr_stb_d;
      r_rd_stb     <= w_rd_stb_d;
      r_wr_stb     <= w_wr_stb_d;
      r_ack        <= w_ack_d;
      r_err        <= w_err_d;
      r_rdata0     <= w_rdata0_d;
      r_rdata1     <= w_rdata1_d;
      r_busy       <= w_busy_d;
    end
  end

  assign bus.s_addr_strobe  = r_addr_stb;
  assign bus.s_read_strobe  = r_rd_stb;
  assign bus.s_write_strobe = r_wr_stb;
  assign bus.s_address      = r_address;
  assign bus.s_byte_enable  = r_be;
  assign bus.s_write_data   = r_wdata;
  assign bus.m0_ack         = r_ack[0];
  assign bus.m1_ack         = r_ack[1];
  assign bus.m0_err         = r_err[0];
  assign bus.m1_err         = r_err[1];
  assign bus.m0_rdata       = r_rdata0;
  assign bus.m1_rdata       = r_rdata1;
  assign bus.busy           = r_busy;

endmodule

// File: tb/tb_iobus_arbiter.sv
// Self-checking bench for iobus_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant order, latency and read data.
module tb_iobus_arbiter;

  localparam int unsigned TO = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  iobus_arbiter_if bus ();

  iobus_arbiter #(
    .TIMEOUT  (TO),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.m0_we = 1'b0; bus.m1_we = 1'b0;
    bus.m0_addr = '0; bus.m1_addr = '0; bus.m0_be = '0; bus.m1_be = '0;
    bus.m0_wdata = '0; bus.m1_wdata = '0; bus.s_read_data = '0; bus.s_ready = 1'b0;
  endtask

  task automatic wiggle();
    bus.m0_we = 1'($urandom_range(0, 1)); bus.m1_we = 1'($urandom_range(0, 1));
    bus.m0_addr = $urandom(); bus.m1_addr = $urandom();
    bus.m0_be = 4'($urandom()); bus.m1_be = 4'($urandom());
    bus.m0_wdata = $urandom(); bus.m1_wdata = $urandom();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    n_cmp++;
    if ({bus.s_addr_strobe, bus.s_read_strobe, bus.s_write_strobe, bus.busy} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b%b%b busy %b want 0000", bus.s_addr_strobe,
               bus.s_read_strobe, bus.s_write_strobe, bus.busy);
    end
    n_cmp++;
    if ({bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_acks: got %b%b%b%b want 0000", bus.m0_ack, bus.m1_ack,
               bus.m0_err, bus.m1_err);
    end
    n_cmp++;
    if ({bus.m0_rdata, bus.m1_rdata, bus.s_address, bus.s_byte_enable, bus.s_write_data}
        !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got rd %h/%h addr %h be %h wd %h want all zero",
               bus.m0_rdata, bus.m1_rdata, bus.s_address, bus.s_byte_enable,
               bus.s_write_data);
    end
    rst_n = 1'b1;
    bus.s_ready = 1'b1;
    tick();
    bus.s_ready = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.m0_ack, bus.m1_ack} !== 3'b0) begin
      n_bad++;
      $display("FAIL idle_ready_ignored: got busy %b acks %b%b want 0 00", bus.busy,
               bus.m0_ack, bus.m1_ack);
    end
  endtask

  task automatic test_single_read();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'hC000_0010; bus.m0_be = 4'hF;
    tick();
    n_cmp++;
    if ({bus.s_addr_strobe, bus.s_read_strobe, bus.s_write_strobe} !== 3'b110 ||
        bus.s_address !== 32'hC000_0010) begin
      n_bad++;
      $display("FAIL rd_strobe: got %b%b%b addr %h want 110 addr c0000010",
               bus.s_addr_strobe, bus.s_read_strobe, bus.s_write_strobe, bus.s_address);
    end
    tick();
    n_cmp++;
    if ({bus.s_addr_strobe, bus.s_read_strobe, bus.s_write_strobe, bus.busy,
         bus.m0_ack} !== 5'b00010) begin
      n_bad++;
      $display("FAIL rd_wait: got strobes %b%b%b busy %b ack %b want 000 1 0",
               bus.s_addr_strobe, bus.s_read_strobe, bus.s_write_strobe, bus.busy, bus.m0_ack);
    end
    tick();
    tick();
    bus.s_ready = 1'b1; bus.s_read_data = 32'h1234_5678;
    tick();
    bus.s_ready = 1'b0;
    n_cmp++;
    if ({bus.m0_ack, bus.m0_err, bus.m1_ack} !== 3'b100 || bus.m0_rdata !== 32'h1234_5678)
    begin
      n_bad++;
      $display("FAIL rd_ack: got ack %b err %b m1_ack %b rdata %h want 1 0 0 12345678",
               bus.m0_ack, bus.m0_err, bus.m1_ack, bus.m0_rdata);
    end
    bus.m0_req = 1'b0;
    tick();
    n_cmp++;
    if ({bus.m0_ack, bus.busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL rd_after: got ack %b busy %b want 0 0", bus.m0_ack, bus.busy);
    end
  endtask

  task automatic test_write();
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'hC000_0004;
    bus.m1_be = 4'b0011; bus.m1_wdata = 32'hA5A5_A5A5;
    tick();
    n_cmp++;
    if ({bus.s_addr_strobe, bus.s_read_strobe, bus.s_write_strobe} !== 3'b101 ||
        {bus.s_address, bus.s_byte_enable, bus.s_write_data} !==
        {32'hC000_0004, 4'b0011, 32'hA5A5_A5A5}) begin
      n_bad++;
      $display("FAIL wr_strobe: got %b%b%b %h %b %h want 101 c0000004 0011 a5a5a5a5",
               bus.s_addr_strobe, bus.s_read_strobe, bus.s_write_strobe, bus.s_address,
               bus.s_byte_enable, bus.s_write_data);
    end
    bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_be = 4'hF; bus.m1_wdata = '0;
    tick();
    n_cmp++;
    if ({bus.s_addr_strobe, bus.s_write_strobe} !== 2'b00 ||
        {bus.s_address, bus.s_byte_enable, bus.s_write_data} !==
        {32'hC000_0004, 4'b0011, 32'hA5A5_A5A5}) begin
      n_bad++;
      $display("FAIL wr_hold: got stb %b%b %h %b %h want 00 c0000004 0011 a5a5a5a5",
               bus.s_addr_strobe, bus.s_write_strobe, bus.s_address, bus.s_byte_enable,
               bus.s_write_data);
    end
    tick();
    bus.s_ready = 1'b1; bus.s_read_data = 32'hFFFF_FFFF;
    tick();
    bus.s_ready = 1'b0;
    n_cmp++;
    if ({bus.m1_ack, bus.m1_err, bus.m0_ack} !== 3'b100 || bus.m1_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL wr_ack: got ack %b err %b m0_ack %b rdata %h want 1 0 0 00000000",
               bus.m1_ack, bus.m1_err, bus.m0_ack, bus.m1_rdata);
    end
    bus.m1_req = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    bit pend, re0, re1, p_exp;
    int nack;
    rst_n = 1'b0;
    idle_inputs();
    bus.m0_req = 1'b1; bus.m1_req = 1'b1; bus.m1_we = 1'b1;
    bus.m0_addr = 32'h0000_0100; bus.m1_addr = 32'h0000_0200;
    tick();
    rst_n = 1'b1;
    pend = 1'b0; re0 = 1'b0; re1 = 1'b0; p_exp = 1'b0; nack = 0;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) tick();
      if (re0) begin bus.m0_req = 1'b1; re0 = 1'b0; end
      if (re1) begin bus.m1_req = 1'b1; re1 = 1'b0; end
      bus.s_ready = pend;
      pend = bus.s_addr_strobe;
      if (bus.m0_ack === 1'b1 || bus.m1_ack === 1'b1) begin
        n_cmp++;
        if (bus.m1_ack !== p_exp || bus.m0_ack === bus.m1_ack || c != 3 + 4 * nack) begin
          n_bad++;
          $display("FAIL rr_grant: ack#%0d got m0=%b m1=%b at cycle %0d want m%0d at %0d",
                   nack, bus.m0_ack, bus.m1_ack, c, p_exp, 3 + 4 * nack);
        end
        if (bus.m0_ack === 1'b1) begin bus.m0_req = 1'b0; re0 = 1'b1; end
        if (bus.m1_ack === 1'b1) begin bus.m1_req = 1'b0; re1 = 1'b1; end
        nack++;
        p_exp = ~p_exp;
      end
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.s_ready = 1'b0;
    n_cmp++;
    if (nack != 4) begin
      n_bad++;
      $display("FAIL rr_count: got %0d acks want 4", nack);
    end
    repeat (2) tick();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rr_idle: got busy %b want 0", bus.busy);
    end
  endtask

  task automatic test_timeout();
    int ack_c;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'hC000_0020;
    ack_c = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus.m0_ack === 1'b1) begin ack_c = c; break; end
    end
    n_cmp++;
    if (ack_c != int'(TO) + 2 || bus.m0_err !== 1'b1 || bus.m0_rdata !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL timeout: got ack cycle %0d err %b rdata %h want %0d 1 deadbeef",
               ack_c, bus.m0_err, bus.m0_rdata, TO + 2);
    end
    bus.m0_req = 1'b0;
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_ready_at_limit();
    int ack_c;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'hC000_0030;
    ack_c = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus.m1_ack === 1'b1) begin ack_c = c; break; end
      bus.s_ready = (c == int'(TO) + 1);
      bus.s_read_data = 32'h0BAD_F00D;
    end
    bus.s_ready = 1'b0;
    n_cmp++;
    if (ack_c != int'(TO) + 2 || bus.m1_err !== 1'b0 || bus.m1_rdata !== 32'h0BAD_F00D) begin
      n_bad++;
      $display("FAIL ready_limit: got ack cycle %0d err %b rdata %h want %0d 0 0badf00d",
               ack_c, bus.m1_err, bus.m1_rdata, TO + 2);
    end
    bus.m1_req = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'hC000_0040;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.s_addr_strobe, bus.s_read_strobe, bus.busy, bus.m0_ack} !== 4'b0 ||
        bus.m1_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL arst_now: got stb %b%b busy %b ack %b m1_rdata %h want 0 0 0 0 0",
               bus.s_addr_strobe, bus.s_read_strobe, bus.busy, bus.m0_ack, bus.m1_rdata);
    end
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'hC000_0050;
    bus.s_ready = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if ({bus.m0_ack, bus.m1_ack} !== 2'b00) begin
      n_bad++;
      $display("FAIL arst_noack: got %b%b want 00", bus.m0_ack, bus.m1_ack);
    end
    bus.s_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bus.s_addr_strobe !== 1'b1 || bus.s_address !== 32'hC000_0040) begin
      n_bad++;
      $display("FAIL arst_first: got stb %b addr %h want 1 c0000040", bus.s_addr_strobe,
               bus.s_address);
    end
    tick();
    bus.s_ready = 1'b1; bus.s_read_data = 32'h5555_AAAA;
    tick();
    bus.s_ready = 1'b0;
    n_cmp++;
    if ({bus.m0_ack, bus.m1_ack} !== 2'b10 || bus.m0_rdata !== 32'h5555_AAAA) begin
      n_bad++;
      $display("FAIL arst_ack: got acks %b%b rdata %h want 10 5555aaaa", bus.m0_ack,
               bus.m1_ack, bus.m0_rdata);
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic        mlast, r0, r1, win, ewe, eerr;
    logic [31:0] mrd [2];
    logic [31:0] eaddr, ewdata, erd;
    logic [3:0]  ebe;
    int          d, w;
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
    mlast = 1'b1; mrd[0] = '0; mrd[1] = '0; erd = '0;
    for (int it = 0; it < 40; it++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r1 = 1'b1;
      wiggle();
      bus.m0_req = r0; bus.m1_req = r1;
      bus.s_ready = 1'($urandom_range(0, 1));
      bus.s_read_data = $urandom();
      win    = (r0 && r1) ? ~mlast : r1;
      ewe    = win ? bus.m1_we    : bus.m0_we;
      eaddr  = win ? bus.m1_addr  : bus.m0_addr;
      ebe    = win ? bus.m1_be    : bus.m0_be;
      ewdata = win ? bus.m1_wdata : bus.m0_wdata;
      d = $urandom_range(0, TO + 1);
      w = (d < int'(TO)) ? d + 1 : int'(TO);
      n_cmp++;
      if (bus.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL rnd_idle[%0d]: got busy %b want 0", it, bus.busy);
      end
      tick();
      n_cmp++;
      if ({bus.s_addr_strobe, bus.s_read_strobe, bus.s_write_strobe, bus.busy} !==
          {1'b1, ~ewe, ewe, 1'b1} ||
          {bus.s_address, bus.s_byte_enable, bus.s_write_data} !== {eaddr, ebe, ewdata}) begin
        n_bad++;
        $display("FAIL rnd_strobe[%0d]: got %b%b%b %h %h %h want 1%b%b %h %h %h", it,
                 bus.s_addr_strobe, bus.s_read_strobe, bus.s_write_strobe, bus.s_address,
                 bus.s_byte_enable, bus.s_write_data, ~ewe, ewe, eaddr, ebe, ewdata);
      end
      wiggle();
      bus.s_ready = 1'($urandom_range(0, 1));
      for (int k = 0; k < w; k++) begin
        tick();
        bus.s_ready = (k == d);
        if (k == d) begin erd = $urandom(); bus.s_read_data = erd; end
        else bus.s_read_data = $urandom();
        n_cmp++;
        if ({bus.s_addr_strobe, bus.s_read_strobe, bus.s_write_strobe, bus.m0_ack,
             bus.m1_ack, bus.busy} !== 6'b000001 || bus.s_address !== eaddr) begin
          n_bad++;
          $display("FAIL rnd_wait[%0d.%0d]: got stb %b%b%b ack %b%b busy %b addr %h want %h",
                   it, k, bus.s_addr_strobe, bus.s_read_strobe, bus.s_write_strobe,
                   bus.m0_ack, bus.m1_ack, bus.busy, bus.s_address, eaddr);
        end
        wiggle();
      end
      tick();
      eerr = (d >= int'(TO));
      if (!ewe) mrd[win] = eerr ? 32'hDEADBEEF : erd;
      n_cmp++;
      if ({bus.m1_ack, bus.m0_ack, bus.m1_err, bus.m0_err} !==
          {win, ~win, win & eerr, ~win & eerr}) begin
        n_bad++;
        $display("FAIL rnd_ack[%0d]: got ack %b%b err %b%b want m%0d err %b", it,
                 bus.m1_ack, bus.m0_ack, bus.m1_err, bus.m0_err, win, eerr);
      end
      n_cmp++;
      if ({bus.m1_rdata, bus.m0_rdata} !== {mrd[1], mrd[0]}) begin
        n_bad++;
        $display("FAIL rnd_rdata[%0d]: got %h/%h want %h/%h", it, bus.m1_rdata,
                 bus.m0_rdata, mrd[1], mrd[0]);
      end
      mlast = win;
      bus.m0_req = 1'b0; bus.m1_req = 1'b0;
      bus.s_ready = 1'($urandom_range(0, 1));
      tick();
    end
    bus.s_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_timeout();
    test_ready_at_limit();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iobus_arbiter.md
Name: iobus_arbiter

Overview:
- Two-master arbiter sharing one MicroBlaze-MCS-style IO bus target (e.g. the iobus peripheral mux / SDRAM path) between requesters such as the CPU bridge and a DMA engine.
- Round-robin grant; one outstanding transaction at a time.
- Single-cycle strobe issue to the target; bus timeout returns an error to the requester instead of hanging.

Parameters:
- TIMEOUT, 255, max WAIT cycles for s_ready before error completion (1..65535).
- ERR_DATA, 32'hDEADBEEF, read data returned on timeout.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req, m1_req  in  1 each  request level; held until ack.
- m0_we, m1_we  in  1 each  1=write, 0=read; valid while req.
- m0_addr, m1_addr  in  32 each  address.
- m0_be, m1_be  in  4 each  byte enables.
- m0_wdata, m1_wdata  in  32 each  write data.
- m0_ack, m1_ack  out  1 each  one-cycle completion pulse.
- m0_err, m1_err  out  1 each  timeout flag, valid with ack.
- m0_rdata, m1_rdata  out  32 each  read data, updated at ack, held otherwise.
- s_addr_strobe, s_read_strobe, s_write_strobe  out  1 each  target strobes.
- s_address  out  32  target address.
- s_byte_enable  out  4  target byte enables.
- s_write_data  out  32  target write data.
- s_read_data  in  32  target read data.
- s_ready  in  1  target completion.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE; all strobes, acks, errs, busy = 0; rdata, s_address, s_byte_enable, s_write_data = 0; timeout counter = 0; last_grant = 1 (m0 wins the first contention). Reset during STROBE or WAIT abandons the transaction with no ack.
- All outputs are registered.
- FSM states: IDLE, STROBE, WAIT, DONE.
- IDLE:
  - One req → grant it.
  - Both req → grant the port != last_grant.
  - On grant: latch we/addr/be/wdata into the s_* registers, record the granted port in last_grant, go to STROBE.
  - s_ready in IDLE is ignored.
- STROBE (exactly 1 cycle):
  - s_addr_strobe = 1; s_read_strobe = ~we; s_write_strobe = we.
  - Clear the counter; go to WAIT.
  - s_ready in this cycle is ignored.
- WAIT:
  - Strobes 0; s_address/be/wdata held stable.
  - s_ready = 1 → capture s_read_data (reads only; writes leave rdata unchanged), go to DONE with err = 0.
  - Else counter++. When the counter reaches TIMEOUT with s_ready low → go to DONE with err = 1; rdata = ERR_DATA for reads.
  - s_ready in the same cycle the counter hits TIMEOUT → normal completion (ready wins).
- DONE (1 cycle):
  - Granted port's ack = 1 and err per above; the other port's ack = 0. Next state IDLE.
- Requester rule: deassert req on the edge that samples ack = 1. Req high in the cycle after ack is a new request.
- Latency: req high at cycle 0 → strobe at cycle 1 → earliest s_ready at cycle 2 → ack at cycle 3. Back-to-back ack spacing ≥ 4 cycles.
- Fairness: under continuous contention, grants alternate m0, m1, m0, ...
- Late s_ready after a timeout arriving in IDLE is dropped. A late s_ready arriving in a later WAIT completes that transaction; this is a documented target-fault limitation.
- Changes to the non-granted port's inputs have no effect. Changes to the granted port's inputs after the grant are ignored because they are latched.

Test Plan:
- Single read: m0 read addr 0xC0000010, s_ready at cycle 4 with data 0x12345678 → s_addr_strobe + s_read_strobe one cycle at cycle 1; m0_ack at cycle 5, m0_rdata = 0x12345678, m0_err = 0.
- Write: m1 write addr 0xC0000004, be 4'b0011, wdata 0xA5A5A5A5 → s_write_strobe with s_address/be/wdata matching; held until s_ready; m1_ack pulse; m1_rdata unchanged.
- Contention: m0 and m1 requesting continuously from reset, target ready 1 cycle after strobe → grant order m0, m1, m0, m1; each ack 4 cycles apart.
- Timeout: TIMEOUT = 8, m0 read, target never ready → m0_ack with m0_err = 1 and m0_rdata = 0xDEADBEEF 8 WAIT cycles after the strobe; busy low the following cycle.
- Ready at the limit: s_ready asserted on the cycle the counter reaches TIMEOUT → err = 0, real data returned.
- Async reset mid-WAIT: pull rst_n low → strobes/busy = 0 immediately; no ack; after release, first contention grants m0.
